// File: rtl/aes_11cc_sched.sv
// aes_11cc_sched: round-robin two-client scheduler around one iterative aes_11cc core.
// aes_11cc: AES-128, operands loaded while rst is high, o valid 11 cycles after load.
module aes_11cc (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] g_init,
    input  logic [127:0] e_init,
    output logic [127:0] o
);
    logic [127:0] s, k, sb, mc, nk;
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [3:0]   r;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254, then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p, v;
        p = x;
        v = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            v = gmul(v, p);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] x);
        logic [7:0] a0, a1, a2, a3;
        {a3, a2, a1, a0} = x;
        return {gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02),
                a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3};
    endfunction

    // Byte b sits at bits [8b+7:8b]; row = b%4, column = b/4.
    always_comb begin
        for (int b = 0; b < 16; b++)
            sb[8*b +: 8] = sbox(s[8*(4*(((b/4) + (b%4)) % 4) + (b%4)) +: 8]);
        for (int c = 0; c < 4; c++)
            mc[32*c +: 32] = mix(sb[32*c +: 32]);
        rc = 8'h01;
        for (int i = 0; i < 10; i++)
            rc = (i < int'(r)) ? gmul(rc, 8'h02) : rc;
        t = {sbox(k[103:96]), sbox(k[127:120]), sbox(k[119:112]), sbox(k[111:104]) ^ rc};
        nk[31:0]   = k[31:0] ^ t;
        nk[63:32]  = k[63:32] ^ nk[31:0];
        nk[95:64]  = k[95:64] ^ nk[63:32];
        nk[127:96] = k[127:96] ^ nk[95:64];
    end

    always_ff @(posedge clk)
        if (rst) begin
            s <= e_init;
            k <= g_init;
            r <= 4'd0;
        end else if (r != 4'd11) begin
            s <= ((r == 4'd0) ? s : (r == 4'd10) ? sb : mc) ^ k;
            k <= nk;
            r <= r + 4'd1;
        end

    assign o = s;
endmodule

module aes_11cc_sched #(
    parameter int unsigned CORE_CC = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_key,
    input  logic [127:0] req0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_key,
    input  logic [127:0] req1_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_id,
    output logic         busy
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, RESP} state_t;
    state_t       state, next;
    logic [3:0]   cnt;
    logic         rr, gnt, acc, op_id;
    logic [127:0] op_key, op_data, o;

    // A lone valid requester wins regardless of the round-robin pointer.
    assign gnt        = (req0_valid & req1_valid) ? rr : req1_valid;
    assign req0_ready = ~rst & (state == IDLE) & req0_valid & ~gnt;
    assign req1_ready = ~rst & (state == IDLE) & req1_valid & gnt;
    assign acc        = req0_ready | req1_ready;
    assign busy       = state != IDLE;

    always_comb
        next = (state == IDLE) ? (acc ? LOAD : IDLE) :
               (state == LOAD) ? RUN :
               (state == RUN)  ? ((cnt == 4'(CORE_CC - 1)) ? CAPT : RUN) :
               (state == CAPT) ? RESP :
               (rsp_ready ? IDLE : RESP);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rr        <= 1'b0;
            op_key    <= '0;
            op_data   <= '0;
            op_id     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
        end else begin
            state <= next;
            cnt   <= (state == RUN) ? cnt + 4'd1 : 4'd0;
            if (acc) begin
                op_key  <= gnt ? req1_key : req0_key;
                op_data <= gnt ? req1_data : req0_data;
                op_id   <= gnt;
            end
            if (state == CAPT) begin
                rsp_data  <= o;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rr        <= ~rsp_id;
            end
        end

    // The core loads the operand registers during the single LOAD cycle.
    aes_11cc core (
        .clk(clk),
        .rst(rst | (state == LOAD)),
        .g_init(op_key),
        .e_init(op_data),
        .o(o)
    );
endmodule

// File: tb/tb_aes_11cc_sched.sv
// tb_aes_11cc_sched: randomized jobs checked against a job-level scheduler model and a byte-array AES model.
module tb_aes_11cc_sched;
    logic         clk = 0, rst = 1, rsp_ready = 0;
    logic         req0_valid = 0, req1_valid = 0;
    logic [127:0] req0_key = 0, req0_data = 0, req1_key = 0, req1_data = 0;
    logic         req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [127:0] rsp_data;

    aes_11cc_sched dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key), .req1_data(req1_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;

    typedef struct packed {logic id; int t;} acc_t;
    typedef struct packed {logic id; int t; int rise; logic [127:0] data;} rsp_t;
    acc_t         acc_q[$];
    rsp_t         rsp_q[$];
    logic [255:0] pend0[$], pend1[$];
    logic [127:0] exp0[$], exp1[$];
    logic         exp_ids[$];
    logic         hs0 = 0, hs1 = 0, last_v = 0, rr_model = 0;
    int           rise = 0, r0_hi = 0;
    logic [7:0]   sbox_t[256];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= a;
            a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [127:0] ce(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = x[127-8*i -: 8];
        return y;
    endfunction

    // FIPS-197 AES-128 on big-endian vectors, state st[row + 4*col], full key schedule up front.
    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   st[16], tmp[16], w[176], t[4], rc;
        logic [127:0] out;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) w[i] = key[127-8*i -: 8];
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-4+j];
            if (i % 16 == 0) begin
                t = '{sbox_t[w[i-3]] ^ rc, sbox_t[w[i-2]], sbox_t[w[i-1]], sbox_t[w[i-4]]};
                rc = gm(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ t[j];
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) tmp[r+4*c] = sbox_t[st[r+4*((c+r)%4)]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    st[r+4*c] = (rd == 10) ? tmp[r+4*c] :
                        gm(tmp[r+4*c], 8'h02) ^ gm(tmp[(r+1)%4+4*c], 8'h03) ^ tmp[(r+2)%4+4*c] ^ tmp[(r+3)%4+4*c];
            for (int i = 0; i < 16; i++) st[i] ^= w[16*rd+i];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = st[i];
        return out;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Requester drivers: hold valid/key/data until the handshake is observed.
    initial forever begin
        @(posedge clk);
        #1;
        if (hs0) begin pend0.delete(0); hs0 = 0; end
        if (hs1) begin pend1.delete(0); hs1 = 0; end
        req0_valid = pend0.size() != 0;
        req1_valid = pend1.size() != 0;
        {req0_key, req0_data} = req0_valid ? pend0[0] : 256'd0;
        {req1_key, req1_data} = req1_valid ? pend1[0] : 256'd0;
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (req0_ready) r0_hi++;
            if (rsp_valid && !last_v) rise = cyc;
            if (req0_ready && req0_valid) begin acc_q.push_back('{1'b0, cyc + 1}); hs0 = 1; end
            if (req1_ready && req1_valid) begin acc_q.push_back('{1'b1, cyc + 1}); hs1 = 1; end
            if (rsp_valid && rsp_ready) rsp_q.push_back('{rsp_id, cyc + 1, rise, rsp_data});
        end
        last_v = rsp_valid;
    end

    task automatic push_job(input logic id, input logic [127:0] k, input logic [127:0] p);
        if (id) begin pend1.push_back({ce(k), ce(p)}); exp1.push_back(ce(aes_ref(k, p))); end
        else begin pend0.push_back({ce(k), ce(p)}); exp0.push_back(ce(aes_ref(k, p))); end
    endtask

    // Job-level grant order for jobs all queued before the first grant.
    task automatic predict(input int n0, input int n1);
        logic g;
        exp_ids.delete();
        while (n0 + n1 > 0) begin
            g = (n0 > 0 && n1 > 0) ? rr_model : (n1 > 0);
            exp_ids.push_back(g);
            if (g) n1--; else n0--;
            rr_model = ~g;
        end
    endtask

    task automatic start_reset();
        rst = 1; rsp_ready = 0;
        pend0.delete(); pend1.delete(); exp0.delete(); exp1.delete();
        acc_q.delete(); rsp_q.delete();
        hs0 = 0; hs1 = 0; r0_hi = 0; rr_model = 0;
    endtask

    task automatic end_reset();
        repeat (2) @(posedge clk);
        #2 rst = 0;
    endtask

    task automatic wait_rsp(input int n, input int budget);
        for (int i = 0; i < budget && rsp_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        start_reset();
        push_job(0, rnd128(), rnd128());
        push_job(1, rnd128(), rnd128());
        rsp_ready = 1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rsp_valid !== 0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_data !== 0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        checks++; if (rsp_id !== 0) begin failures++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); end
        start_reset();
        end_reset();
    endtask

    task automatic test_single();
        start_reset(); end_reset();
        rsp_ready = 1;
        push_job(0, 128'he4dc18adf3d05ec9e4dcc41acb990007, 128'h4072da1240f930f7d3c8cf8b9322042e);
        wait_rsp(1, 60);
        checks++;
        if (rsp_q.size() != 1 || acc_q.size() != 1) begin
            failures++; $display("FAIL single_count rsp=%0d acc=%0d exp=1/1", rsp_q.size(), acc_q.size()); return;
        end
        checks++; if (r0_hi != 1) begin failures++; $display("FAIL single_ready_pulse got=%0d cycles exp=1", r0_hi); end
        checks++; if (rsp_q[0].rise - acc_q[0].t != 13) begin failures++; $display("FAIL single_latency got=%0d exp=13", rsp_q[0].rise - acc_q[0].t); end
        checks++; if (rsp_q[0].data !== ce(128'hd225406f484809186cb5d86be4098445)) begin failures++; $display("FAIL single_data got=%h exp=%h", rsp_q[0].data, ce(128'hd225406f484809186cb5d86be4098445)); end
        checks++; if (rsp_q[0].id !== 0) begin failures++; $display("FAIL single_id got=%b exp=0", rsp_q[0].id); end
        @(negedge clk);
        checks++; if (busy !== 0 || rsp_valid !== 0) begin failures++; $display("FAIL single_idle busy=%b rsp_valid=%b exp=0/0", busy, rsp_valid); end
    endtask

    task automatic test_simultaneous();
        logic [127:0] want;
        start_reset();
        push_job(0, rnd128(), rnd128());
        push_job(1, rnd128(), rnd128());
        predict(1, 1);
        end_reset();
        rsp_ready = 1;
        wait_rsp(2, 80);
        checks++;
        if (rsp_q.size() != 2) begin failures++; $display("FAIL simul_count got=%0d exp=2", rsp_q.size()); return; end
        for (int i = 0; i < 2; i++) begin
            if (exp_ids[i]) want = exp1.pop_front(); else want = exp0.pop_front();
            checks++; if (acc_q[i].id !== exp_ids[i]) begin failures++; $display("FAIL simul_grant%0d got=%b exp=%b", i, acc_q[i].id, exp_ids[i]); end
            checks++; if (rsp_q[i].id !== exp_ids[i]) begin failures++; $display("FAIL simul_rsp_id%0d got=%b exp=%b", i, rsp_q[i].id, exp_ids[i]); end
            checks++; if (rsp_q[i].data !== want) begin failures++; $display("FAIL simul_data%0d got=%h exp=%h", i, rsp_q[i].data, want); end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] d;
        logic         id;
        start_reset();
        push_job(0, rnd128(), rnd128());
        push_job(1, rnd128(), rnd128());
        predict(1, 1);
        end_reset();
        for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
        checks++;
        if (rsp_valid !== 1) begin failures++; $display("FAIL bp_rsp_valid got=%b exp=1", rsp_valid); return; end
        d = rsp_data; id = rsp_id;
        checks++; if (id !== exp_ids[0] || d !== exp0[0]) begin failures++; $display("FAIL bp_first got id=%b data=%h exp id=%b data=%h", id, d, exp_ids[0], exp0[0]); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1 || rsp_data !== d || rsp_id !== id || req0_ready !== 0 || req1_ready !== 0 || busy !== 1) begin
                failures++;
                $display("FAIL bp_hold%0d got v=%b id=%b rdy=%b%b busy=%b data=%h exp v=1 id=%b rdy=00 busy=1 data=%h",
                         i, rsp_valid, rsp_id, req0_ready, req1_ready, busy, rsp_data, id, d);
            end
        end
        #1 rsp_ready = 1;
        @(negedge clk);
        checks++; if (rsp_valid !== 0 || busy !== 0) begin failures++; $display("FAIL bp_release rsp_valid=%b busy=%b exp=0/0", rsp_valid, busy); end
        checks++; if (req1_ready !== 1 || req0_ready !== 0) begin failures++; $display("FAIL bp_next_grant got=%b%b exp=01", req0_ready, req1_ready); end
        wait_rsp(1, 40);
        checks++;
        if (rsp_q.size() != 1) begin failures++; $display("FAIL bp_second_count got=%0d exp=1", rsp_q.size()); return; end
        checks++; if (rsp_q[0].id !== exp_ids[1] || rsp_q[0].data !== exp1[0]) begin failures++; $display("FAIL bp_second got id=%b data=%h exp id=%b data=%h", rsp_q[0].id, rsp_q[0].data, exp_ids[1], exp1[0]); end
    endtask

    task automatic test_fairness();
        logic [127:0] want;
        start_reset(); end_reset();
        rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            push_job(0, rnd128(), rnd128());
            push_job(1, rnd128(), rnd128());
        end
        predict(4, 4);
        wait_rsp(8, 200);
        checks++;
        if (rsp_q.size() != 8 || acc_q.size() != 8) begin failures++; $display("FAIL fair_count rsp=%0d acc=%0d exp=8/8", rsp_q.size(), acc_q.size()); return; end
        for (int i = 0; i < 8; i++) begin
            if (exp_ids[i]) want = exp1.pop_front(); else want = exp0.pop_front();
            checks++; if (acc_q[i].id !== exp_ids[i]) begin failures++; $display("FAIL fair_grant%0d got=%b exp=%b", i, acc_q[i].id, exp_ids[i]); end
            checks++; if (rsp_q[i].id !== exp_ids[i] || rsp_q[i].data !== want) begin failures++; $display("FAIL fair_rsp%0d got id=%b data=%h exp id=%b data=%h", i, rsp_q[i].id, rsp_q[i].data, exp_ids[i], want); end
        end
        for (int i = 1; i < 6; i++) begin
            checks++; if (acc_q[i].t - acc_q[i-1].t != 15) begin failures++; $display("FAIL fair_period%0d got=%0d exp=15", i, acc_q[i].t - acc_q[i-1].t); end
        end
    endtask

    task automatic test_work_conserving();
        int c;
        start_reset(); end_reset();
        rsp_ready = 1;
        @(negedge clk);
        c = cyc;
        push_job(1, rnd128(), rnd128());
        wait_rsp(1, 40);
        checks++;
        if (rsp_q.size() != 1) begin failures++; $display("FAIL wc_count got=%0d exp=1", rsp_q.size()); return; end
        checks++; if (acc_q[0].id !== 1 || acc_q[0].t != c + 2) begin failures++; $display("FAIL wc_grant got id=%b t=%0d exp id=1 t=%0d", acc_q[0].id, acc_q[0].t, c + 2); end
        checks++; if (rsp_q[0].id !== 1) begin failures++; $display("FAIL wc_rsp_id got=%b exp=1", rsp_q[0].id); end
        checks++; if (rsp_q[0].data !== exp1[0]) begin failures++; $display("FAIL wc_data got=%h exp=%h", rsp_q[0].data, exp1[0]); end
    endtask

    task automatic test_mid_reset();
        int a;
        start_reset(); end_reset();
        rsp_ready = 1;
        push_job(0, rnd128(), rnd128());
        for (int i = 0; i < 20 && acc_q.size() == 0; i++) @(negedge clk);
        checks++;
        if (acc_q.size() != 1) begin failures++; $display("FAIL mid_accept got=%0d exp=1", acc_q.size()); return; end
        a = acc_q[0].t;
        while (cyc < a + 6) begin @(posedge clk); #1; end
        rst = 1;
        #1;
        checks++; if (busy !== 0 || rsp_valid !== 0 || rsp_id !== 0 || rsp_data !== 0) begin failures++; $display("FAIL mid_outputs got busy=%b v=%b id=%b data=%h exp all 0", busy, rsp_valid, rsp_id, rsp_data); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL mid_ready got=%b%b exp=00", req0_ready, req1_ready); end
        start_reset(); end_reset();
        rsp_ready = 1;
        repeat (30) @(negedge clk);
        checks++; if (rsp_q.size() != 0 || rsp_valid !== 0 || busy !== 0) begin failures++; $display("FAIL mid_dropped got rsp=%0d v=%b busy=%b exp 0/0/0", rsp_q.size(), rsp_valid, busy); end
        push_job(0, rnd128(), rnd128());
        wait_rsp(1, 60);
        checks++;
        if (rsp_q.size() != 1 || acc_q.size() != 1) begin failures++; $display("FAIL mid_fresh_count rsp=%0d acc=%0d exp=1/1", rsp_q.size(), acc_q.size()); return; end
        checks++; if (rsp_q[0].rise - acc_q[0].t != 13) begin failures++; $display("FAIL mid_latency got=%0d exp=13", rsp_q[0].rise - acc_q[0].t); end
        checks++; if (rsp_q[0].id !== 0 || rsp_q[0].data !== exp0[0]) begin failures++; $display("FAIL mid_fresh got id=%b data=%h exp id=0 data=%h", rsp_q[0].id, rsp_q[0].data, exp0[0]); end
    endtask

    initial begin
        logic [7:0] inv, s;
        logic [7:0] c63;
        c63 = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
            sbox_t[x] = s;
        end
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_fairness();
        test_work_conserving();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/aes_11cc_sched.md
# aes_11cc_sched

Two-requester scheduler that shares one `aes_11cc` core between two independent clients. It arbitrates round-robin and latches the winner's key and plaintext. It then sequences the core's load-then-run protocol: one cycle with core reset high, then `CORE_CC` run cycles. It captures the ciphertext and returns it through a valid/ready response port tagged with the requester id. The block instantiates `aes_11cc` internally and sits between the garbled-circuit front end and the single AES datapath.

## Interface
- `CORE_CC`, default 11: number of core clock cycles after the load cycle until the core's `o` is valid. Legal range 1..15.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` in 1: requester 0 has a job.
- `req0_ready` out 1: requester 0 job accepted this cycle.
- `req0_key` in 128: requester 0 key, drives core `g_init`.
- `req0_data` in 128: requester 0 plaintext, drives core `e_init`.
- `req1_valid`, `req1_ready`, `req1_key`, `req1_data`: same as requester 0, for requester 1.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_data` out 128: ciphertext, the core `o` passed unchanged.
- `rsp_id` out 1: id of the requester that owns `rsp_data`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- Operands pass to the core bit-for-bit. Byte-order conversion (`changeEndian`) is the requesters' responsibility.
- FSM states: IDLE, LOAD, RUN, CAPT, RESP.
- **IDLE**
  - Grant goes to the valid requester selected by the round-robin pointer `rr`. When both are valid, `rr`=0 favors requester 0 and `rr`=1 favors requester 1.
  - If only one requester is valid, it wins regardless of `rr` (work-conserving).
  - `reqN_ready` is combinational and asserted only in IDLE, only to the grantee, and only while it is valid.
  - On handshake: latch key, data and id into operand registers; go to LOAD.
- **LOAD**
  - Core `rst` = `rst | (state==LOAD)`, so the core samples the operand registers at the end of this cycle.
  - Clear counter `cnt` (4 bits); go to RUN.
- **RUN**
  - Increment `cnt` each cycle.
  - When `cnt==CORE_CC-1`, go to CAPT. RUN therefore lasts exactly `CORE_CC` cycles.
- **CAPT**
  - Core `o` is valid here.
  - At the end of the cycle: `rsp_data`<=`o`, `rsp_id`<=latched id, `rsp_valid`<=1; go to RESP.
- **RESP**
  - Hold `rsp_valid`, `rsp_data` and `rsp_id` stable until `rsp_ready`.
  - On handshake: `rsp_valid`<=0, `rr`<=~`rsp_id`, go to IDLE.
- Requester rule: once `reqN_valid` is high, key and data must stay stable until `reqN_ready`. Dropping valid before the grant is allowed and produces no job.
- Only one job is in flight at a time. Requester ready signals stay 0 in every state other than IDLE.

## Timing
- Reset values (asynchronous, effective immediately on `rst` high):
  - State IDLE; `cnt`=0; `rr`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0, `req0_ready`=`req1_ready`=0.
  - Operand registers = 0; core held in reset.
- Let A be the accept edge. LOAD occupies A..A+1, RUN covers edges A+2..A+CORE_CC+1, and CAPT ends at edge A+CORE_CC+2. `rsp_valid` first rises after edge A+13 (`CORE_CC`=11).
- Minimum job period is 15 cycles with `rsp_ready` tied high: LOAD 1 + RUN 11 + CAPT 1 + RESP 1 + IDLE 1.
- Reset mid-operation in any state:
  - The job is dropped with no response.
  - Operand registers and the core are cleared.
  - The first IDLE cycle after `rst` deasserts accepts a new request.
- Simultaneous `rsp_ready` and new request valids in RESP: the response handshake completes, and the request is evaluated next cycle in IDLE using the updated `rr`.
- `rsp_ready` high while `rsp_valid` is 0 has no effect.

## Test plan
- **Single job, requester 0.** After reset, `req0_valid`=1 with `req0_key`=changeEndian(128'he4dc18adf3d05ec9e4dcc41acb990007) and `req0_data`=changeEndian(128'h4072da1240f930f7d3c8cf8b9322042e); `rsp_ready`=1.
  - Required: `req0_ready` pulses for 1 cycle, `rsp_valid` rises 13 cycles after accept, `rsp_data`=changeEndian(128'hd225406f484809186cb5d86be4098445), `rsp_id`=0.
- **Simultaneous requests, both valid from reset with distinct vectors.** Required: requester 0 granted first and requester 1 on the next IDLE. Responses arrive in order with id 0 then id 1, each data matching the software AES model.
- **Backpressure.** `rsp_ready`=0 for 20 cycles after `rsp_valid` rises, with both requesters valid.
  - Required: `rsp_valid`/`rsp_data`/`rsp_id` constant, both readys 0, `busy`=1.
  - On `rsp_ready`=1: one handshake, then IDLE.
- **Fairness.** Both requesters continuously valid for 6 jobs. Required: grant sequence 0,1,0,1,0,1 and a job period of 15 cycles.
- **Work-conserving.** Only `req1_valid`=1 with `rr`=0. Required: requester 1 granted in the first IDLE cycle, `rsp_id`=1.
- **Mid-job reset.** Assert `rst` during RUN at `cnt`=5.
  - Required: all outputs at reset values in the same cycle and no response for the dropped job.
  - After release, a fresh job on requester 0 completes correctly with 13-cycle latency.
